// File: rtl/cfg_sched_pkg.sv
// Shared types and helpers for the config-change stream scheduler.
package cfg_sched_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    function automatic int ch_bits(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Replicates bit w-1 of v into every bit position at and above w.
    function automatic logic [63:0] sign_ext(input logic [63:0] v, input int w);
        logic [63:0] r;
        for (int b = 0; b < 64; b++) begin
            r[b] = (b < w) ? v[b] : v[w-1];
        end
        return r;
    endfunction

endpackage

// File: rtl/cfg_axis_update_sched_rr_arbiter.sv
// Combinational round-robin pick: first request at or after rr_ptr+1, wrapping.
module rr_arbiter
    import cfg_sched_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CH_BITS = ch_bits(NUM_CH)
) (
    input  logic [NUM_CH-1:0]  req,
    input  logic [CH_BITS-1:0] rr_ptr,
    input  logic               enable,
    output logic [CH_BITS-1:0] grant,
    output logic               grant_valid
);

    int idx;

    // Scan from farthest to nearest so the nearest requester overwrites the rest.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        idx         = 0;
        for (int i = NUM_CH; i >= 1; i--) begin
            idx = (int'(rr_ptr) + i) % NUM_CH;
            if (enable && req[idx]) begin
                grant       = CH_BITS'(idx);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cfg_axis_update_sched.sv
// Detects changes on watched cfg words and streams them out round-robin on AXI-Stream.
// Optional periodic full refresh is enabled by defining CFG_SCHED_REFRESH_EN.
module cfg_axis_update_sched
    import cfg_sched_pkg::*;
#(
    parameter int SRC_ADDR          = 0,
    parameter int NUM_CH            = 4,
    parameter int SRC_BITS          = 32,
    parameter int CFG_WIDTH         = 1024,
    parameter int DST_WIDTH         = 32,
    parameter int MAXIS_TDATA_WIDTH = 32,
    parameter int REFRESH_CYCLES    = 1000000,
    localparam int CH_BITS          = ch_bits(NUM_CH)
) (
    input  logic                         a_clk,
    input  logic                         a_resetn,
    input  logic [CFG_WIDTH-1:0]         cfg,
    input  logic                         enable,
    input  logic                         force_all,
    output logic [MAXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
    output logic [CH_BITS-1:0]           M_AXIS_tdest,
    output logic                         M_AXIS_tvalid,
    input  logic                         M_AXIS_tready,
    output logic [NUM_CH-1:0]            pending,
    output logic                         busy
);

    state_t                       state_q, state_d;
    logic [DST_WIDTH-1:0]         field [NUM_CH];
    logic [DST_WIDTH-1:0]         snap_q [NUM_CH];
    logic [DST_WIDTH-1:0]         snap_d [NUM_CH];
    logic [NUM_CH-1:0]            pending_q, pending_d, change, clr_vec;
    logic [CH_BITS-1:0]           rr_q, rr_d, tdest_q, tdest_d, grant;
    logic                         grant_valid, tvalid_q, tvalid_d;
    logic [MAXIS_TDATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                         refresh_hit;
    logic                         unused_cfg;

    assign unused_cfg = ^cfg;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            field[i]  = cfg[(SRC_ADDR+i)*32+SRC_BITS-1 -: DST_WIDTH];
            snap_d[i] = field[i];
            change[i] = (field[i] != snap_q[i]);
        end
    end

`ifdef CFG_SCHED_REFRESH_EN
    localparam int REF_W = (REFRESH_CYCLES <= 1) ? 1 : $clog2(REFRESH_CYCLES);
    logic [REF_W-1:0] refresh_cnt_q, refresh_cnt_d;

    always_comb begin
        refresh_hit   = (refresh_cnt_q == REF_W'(REFRESH_CYCLES-1));
        refresh_cnt_d = refresh_hit ? '0 : refresh_cnt_q + 1'b1;
    end

    always_ff @(posedge a_clk or negedge a_resetn) begin
        if (!a_resetn) refresh_cnt_q <= '0;
        else           refresh_cnt_q <= refresh_cnt_d;
    end
`else
    assign refresh_hit = 1'b0;
`endif

    rr_arbiter #(
        .NUM_CH  (NUM_CH),
        .CH_BITS (CH_BITS)
    ) u_arb (
        .req         (pending_q),
        .rr_ptr      (rr_q),
        .enable      (enable && (state_q == S_IDLE)),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        tdata_d  = tdata_q;
        tdest_d  = tdest_q;
        tvalid_d = tvalid_q;
        clr_vec  = '0;
        case (state_q)
            S_IDLE: begin
                if (grant_valid) begin
                    tdata_d        = MAXIS_TDATA_WIDTH'(sign_ext(64'(snap_q[grant]), DST_WIDTH));
                    tdest_d        = grant;
                    clr_vec[grant] = 1'b1;
                    rr_d           = grant;
                    tvalid_d       = 1'b1;
                    state_d        = S_SEND;
                end
            end
            S_SEND: begin
                if (M_AXIS_tready) begin
                    tvalid_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A set in the grant cycle beats the clear, so the newer value gets resent.
        pending_d = (pending_q & ~clr_vec) | change | {NUM_CH{force_all | refresh_hit}};
    end

    always_ff @(posedge a_clk or negedge a_resetn) begin
        if (!a_resetn) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
            rr_q      <= CH_BITS'(NUM_CH-1);
            tdata_q   <= '0;
            tdest_q   <= '0;
            tvalid_q  <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) snap_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            rr_q      <= rr_d;
            tdata_q   <= tdata_d;
            tdest_q   <= tdest_d;
            tvalid_q  <= tvalid_d;
            for (int i = 0; i < NUM_CH; i++) snap_q[i] <= snap_d[i];
        end
    end

    assign M_AXIS_tdata  = tdata_q;
    assign M_AXIS_tdest  = tdest_q;
    assign M_AXIS_tvalid = tvalid_q;
    assign pending       = pending_q;
    assign busy          = (state_q == S_SEND);

endmodule

// File: tb/tb_cfg_axis_update_sched.sv
// Scoreboard bench for cfg_axis_update_sched with 4 channels and a 16-bit field.
module tb_cfg_axis_update_sched;

    logic          a_clk = 1'b0;
    logic          a_resetn;
    logic [1023:0] cfg;
    logic          enable, force_all;
    logic [31:0]   M_AXIS_tdata;
    logic [1:0]    M_AXIS_tdest;
    logic          M_AXIS_tvalid, M_AXIS_tready;
    logic [3:0]    pending;
    logic          busy;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  dest;
    } beat_t;

    beat_t       exp_q[$];
    int          hs_cyc[$];
    int          hs_dest[$];
    logic [31:0] words [4];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    bit          sb_off = 1'b0;

    cfg_axis_update_sched #(
        .SRC_ADDR          (0),
        .NUM_CH            (4),
        .SRC_BITS          (32),
        .CFG_WIDTH         (1024),
        .DST_WIDTH         (16),
        .MAXIS_TDATA_WIDTH (32),
        .REFRESH_CYCLES    (50)
    ) dut (
        .a_clk         (a_clk),
        .a_resetn      (a_resetn),
        .cfg           (cfg),
        .enable        (enable),
        .force_all     (force_all),
        .M_AXIS_tdata  (M_AXIS_tdata),
        .M_AXIS_tdest  (M_AXIS_tdest),
        .M_AXIS_tvalid (M_AXIS_tvalid),
        .M_AXIS_tready (M_AXIS_tready),
        .pending       (pending),
        .busy          (busy)
    );

    always #5 a_clk = ~a_clk;
    always @(posedge a_clk) cyc++;

    function automatic logic [31:0] exp_data(input logic [31:0] w);
        return {{16{w[31]}}, w[31:16]};
    endfunction

    always @(negedge a_clk) begin
        if (a_resetn && M_AXIS_tvalid && M_AXIS_tready) begin
            beat_t e;
            hs_cyc.push_back(cyc);
            hs_dest.push_back(int'(M_AXIS_tdest));
            if (!sb_off) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_beat: tdata=%h tdest=%0d, none expected", M_AXIS_tdata, M_AXIS_tdest);
                end else begin
                    e = exp_q.pop_front();
                    if (M_AXIS_tdata !== e.data || M_AXIS_tdest !== e.dest) begin
                        bad++;
                        $display("FAIL beat: tdata=%h tdest=%0d want tdata=%h tdest=%0d",
                                 M_AXIS_tdata, M_AXIS_tdest, e.data, e.dest);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge a_clk);
        #1;
    endtask

    task automatic set_word(input int i, input logic [31:0] v);
        words[i] = v;
        cfg[i*32 +: 32] = v;
    endtask

    task automatic push_exp(input int i);
        beat_t b;
        b.data = exp_data(words[i]);
        b.dest = 2'(i);
        exp_q.push_back(b);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        tick(1);
        while (!(exp_q.size() == 0 && !M_AXIS_tvalid && pending == 4'h0) && n < budget) begin
            tick(1);
            n++;
        end
        total++;
        if (n >= budget) begin
            bad++;
            $display("FAIL %s_timeout: queue=%0d pending=%h, want queue=0 pending=0", name, exp_q.size(), pending);
            exp_q.delete();
        end
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n = 0;
        while (!M_AXIS_tvalid && n < budget) begin
            tick(1);
            n++;
        end
        total++;
        if (!M_AXIS_tvalid) begin
            bad++;
            $display("FAIL %s_no_valid: tvalid=0 after %0d cycles, want 1", name, budget);
        end
    endtask

    // Leaves the round-robin pointer on channel 3 so the next scan starts at 0.
    task automatic park_rr3();
        set_word(3, words[3] + 32'h0001_0000);
        push_exp(3);
        wait_idle("park", 40);
    endtask

    task automatic test_reset();
        a_resetn = 1'b0;
        enable = 1'b1;
        force_all = 1'b0;
        M_AXIS_tready = 1'b1;
        cfg = '0;
        for (int i = 0; i < 4; i++) set_word(i, 32'h0);
        set_word(0, 32'h1234_0000);
        tick(3);
        total++;
        if (M_AXIS_tvalid !== 1'b0 || pending !== 4'h0 || busy !== 1'b0 ||
            M_AXIS_tdata !== 32'h0 || M_AXIS_tdest !== 2'd0) begin
            bad++;
            $display("FAIL reset_values: tvalid=%b pending=%h busy=%b tdata=%h tdest=%0d, want all zero",
                     M_AXIS_tvalid, pending, busy, M_AXIS_tdata, M_AXIS_tdest);
        end
        push_exp(0);
        a_resetn = 1'b1;
        tick(1);
        total++;
        if (pending !== 4'h1 || M_AXIS_tvalid !== 1'b0) begin
            bad++;
            $display("FAIL reset_edge1: pending=%h tvalid=%b, want pending=1 tvalid=0", pending, M_AXIS_tvalid);
        end
        tick(1);
        total++;
        if (M_AXIS_tvalid !== 1'b1 || busy !== 1'b1 || M_AXIS_tdata !== 32'h0000_1234 || M_AXIS_tdest !== 2'd0) begin
            bad++;
            $display("FAIL reset_edge2: tvalid=%b busy=%b tdata=%h tdest=%0d, want 1 1 00001234 0",
                     M_AXIS_tvalid, busy, M_AXIS_tdata, M_AXIS_tdest);
        end
        wait_idle("reset", 20);
    endtask

    task automatic test_sign_ext();
        set_word(1, 32'h8001_0000);
        push_exp(1);
        wait_valid("sext", 10);
        total++;
        if (M_AXIS_tdata !== 32'hFFFF_8001 || M_AXIS_tdest !== 2'd1) begin
            bad++;
            $display("FAIL sign_ext: tdata=%h tdest=%0d, want ffff8001 1", M_AXIS_tdata, M_AXIS_tdest);
        end
        wait_idle("sext", 20);
    endtask

    task automatic test_multi();
        int n0;
        park_rr3();
        n0 = hs_cyc.size();
        set_word(0, 32'h0005_0000);
        set_word(2, 32'hC0DE_0000);
        set_word(3, 32'h7FFF_0000);
        push_exp(0);
        push_exp(2);
        push_exp(3);
        wait_idle("multi", 40);
        total++;
        if (hs_cyc.size() - n0 != 3) begin
            bad++;
            $display("FAIL multi_count: beats=%0d, want 3", hs_cyc.size() - n0);
        end else begin
            for (int k = 1; k < 3; k++) begin
                total++;
                if (hs_cyc[n0+k] - hs_cyc[n0+k-1] != 2) begin
                    bad++;
                    $display("FAIL multi_spacing: gap=%0d, want 2", hs_cyc[n0+k] - hs_cyc[n0+k-1]);
                end
            end
        end
        total++;
        if (pending !== 4'h0) begin
            bad++;
            $display("FAIL multi_pending: pending=%h, want 0", pending);
        end
    endtask

    task automatic test_stall();
        logic [31:0] d0;
        logic [1:0]  t0;
        M_AXIS_tready = 1'b0;
        set_word(2, 32'h1111_0000);
        push_exp(2);
        wait_valid("stall", 10);
        d0 = M_AXIS_tdata;
        t0 = M_AXIS_tdest;
        for (int c = 0; c < 20; c++) begin
            if (c == 5) set_word(2, 32'h2222_0000);
            if (c == 10) set_word(2, 32'hA333_0000);
            tick(1);
            total++;
            if (M_AXIS_tvalid !== 1'b1 || M_AXIS_tdata !== d0 || M_AXIS_tdest !== t0) begin
                bad++;
                $display("FAIL stall_stable: tvalid=%b tdata=%h tdest=%0d, want 1 %h %0d",
                         M_AXIS_tvalid, M_AXIS_tdata, M_AXIS_tdest, d0, t0);
            end
        end
        push_exp(2);
        M_AXIS_tready = 1'b1;
        wait_idle("stall", 40);
    endtask

    task automatic test_enable();
        park_rr3();
        enable = 1'b0;
        set_word(1, 32'h0042_0000);
        tick(1);
        force_all = 1'b1;
        tick(1);
        force_all = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick(1);
            total++;
            if (pending !== 4'hF || M_AXIS_tvalid !== 1'b0) begin
                bad++;
                $display("FAIL enable_hold: pending=%h tvalid=%b, want f 0", pending, M_AXIS_tvalid);
            end
        end
        for (int i = 0; i < 4; i++) push_exp(i);
        enable = 1'b1;
        wait_idle("enable", 40);
    endtask

    task automatic test_no_refresh();
        int n0 = hs_cyc.size();
        tick(150);
        total++;
        if (hs_cyc.size() != n0) begin
            bad++;
            $display("FAIL no_refresh: beats=%0d, want 0", hs_cyc.size() - n0);
        end
    endtask

    task automatic test_refresh();
        int n0;
        int z[$];
        sb_off = 1'b1;
        n0 = hs_cyc.size();
        tick(180);
        for (int k = n0; k < hs_cyc.size(); k++) if (hs_dest[k] == 0) z.push_back(k);
        total++;
        if (z.size() < 3) begin
            bad++;
            $display("FAIL refresh_bursts: bursts=%0d, want >=3", z.size());
        end else begin
            for (int k = 1; k < 3; k++) begin
                total++;
                if (hs_cyc[z[k]] - hs_cyc[z[k-1]] != 50 || z[k] - z[k-1] != 4) begin
                    bad++;
                    $display("FAIL refresh_period: gap=%0d beats=%0d, want 50 4",
                             hs_cyc[z[k]] - hs_cyc[z[k-1]], z[k] - z[k-1]);
                end
            end
        end
        sb_off = 1'b0;
    endtask

    initial begin
        test_reset();
`ifdef CFG_SCHED_REFRESH_EN
        test_refresh();
`else
        test_sign_ext();
        test_multi();
        test_stall();
        test_enable();
        test_no_refresh();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
